// File: rtl/hsid_pkg.sv
// Shared HSID widths and constants for the MSE datapath, its comparator and the main FSM.
package hsid_pkg;

  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_DATA_WIDTH        = HSID_WORD_WIDTH / 2;
  localparam int HSID_HSP_BANDS_WIDTH   = 9;
  localparam int HSID_HSP_LIBRARY_WIDTH = 10;
  localparam int HSID_MSE_WIDTH         = 2 * HSID_DATA_WIDTH + HSID_HSP_BANDS_WIDTH;
  localparam int HSID_MSE_LATENCY       = 5;

  // Two bands per pack, so an odd band count still needs a final (half-masked) pack.
  function automatic int unsigned hsid_expected_packs(input int unsigned bands);
    return (bands + 1) / 2;
  endfunction

endpackage

// File: rtl/hsid_sq_df.sv
// Registered squared difference of one band pair: stage 1 holds |a-b|, stage 2 holds its square.
module hsid_sq_df #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   sq
);

  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0]      abs_diff;
  logic [DATA_WIDTH-1:0]      abs_q;

  // One extra sign bit keeps the difference exact before folding to magnitude.
  always_comb begin
    diff     = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = diff[DATA_WIDTH] ? DATA_WIDTH'(-diff) : diff[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_q <= '0;
      sq    <= '0;
    end else begin
      abs_q <= abs_diff;
      sq    <= {{DATA_WIDTH{1'b0}}, abs_q} * {{DATA_WIDTH{1'b0}}, abs_q};
    end
  end

endmodule

// File: rtl/hsid_mse.sv
// Streaming sum-of-squared-errors per reference vector, five register stages deep.
// Optional per-vector pack counter and length check behind `HSID_MSE_STATS_EN.
module hsid_mse
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
  parameter int MSE_WIDTH         = 2 * DATA_WIDTH + HSP_BANDS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [HSP_BANDS_WIDTH-1:0]   cfg_hsp_bands,
  input  logic                         band_pack_valid,
  input  logic                         band_pack_start,
  input  logic                         band_pack_last,
  input  logic [WORD_WIDTH-1:0]        band_pack_a,
  input  logic [WORD_WIDTH-1:0]        band_pack_b,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_count,
  output logic                         mse_valid,
  output logic [MSE_WIDTH-1:0]         mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_ref
`ifdef HSID_MSE_STATS_EN
  ,
  output logic [HSP_BANDS_WIDTH-1:0]   mse_pack_count,
  output logic                         mse_pack_error
`endif
);

  localparam int SQ_WIDTH   = 2 * DATA_WIDTH;
  localparam int PAIR_WIDTH = SQ_WIDTH + 1;

  typedef struct packed {
    logic                         start;
    logic                         last;
    logic                         odd_mask;
    logic [HSP_LIBRARY_WIDTH-1:0] tag;
  } ctrl_t;

  // Index 0..3 follows the data through S1..S4.
  logic [3:0]                vld_q;
  ctrl_t                     ctrl_q [4];
  logic [WORD_WIDTH-1:0]     a_q;
  logic [WORD_WIDTH-1:0]     b_q;
  logic [SQ_WIDTH-1:0]       sq_lo;
  logic [SQ_WIDTH-1:0]       sq_hi;
  logic [SQ_WIDTH-1:0]       sq_hi_masked;
  logic [PAIR_WIDTH-1:0]     pair_q;
  logic [MSE_WIDTH-1:0]      pair_ext;
  logic [MSE_WIDTH-1:0]      acc;
  logic [MSE_WIDTH-1:0]      acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < 4; i++) ctrl_q[i] <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      a_q <= band_pack_a;
      b_q <= band_pack_b;
      for (int i = 1; i < 4; i++) ctrl_q[i] <= ctrl_q[i-1];
      ctrl_q[0].start    <= band_pack_valid & band_pack_start;
      ctrl_q[0].last     <= band_pack_valid & band_pack_last;
      ctrl_q[0].odd_mask <= band_pack_valid & band_pack_last & cfg_hsp_bands[0];
      ctrl_q[0].tag      <= hsp_ref_count;
      if (clear) vld_q <= '0;
      else       vld_q <= {vld_q[2:0], band_pack_valid};
    end
  end

  hsid_sq_df #(.DATA_WIDTH(DATA_WIDTH)) u_sq_lo (
    .clk (clk),
    .rst (rst),
    .a   (a_q[DATA_WIDTH-1:0]),
    .b   (b_q[DATA_WIDTH-1:0]),
    .sq  (sq_lo)
  );

  hsid_sq_df #(.DATA_WIDTH(DATA_WIDTH)) u_sq_hi (
    .clk (clk),
    .rst (rst),
    .a   (a_q[WORD_WIDTH-1:DATA_WIDTH]),
    .b   (b_q[WORD_WIDTH-1:DATA_WIDTH]),
    .sq  (sq_hi)
  );

  // The odd band of the final pack is padding and must not contribute.
  always_comb begin
    sq_hi_masked = ctrl_q[2].odd_mask ? '0 : sq_hi;
    pair_ext     = MSE_WIDTH'(pair_q);
    acc_next     = ctrl_q[3].start ? pair_ext : acc + pair_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pair_q <= '0;
    else     pair_q <= {1'b0, sq_lo} + {1'b0, sq_hi_masked};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      mse_valid <= 1'b0;
      mse_value <= '0;
      mse_ref   <= '0;
    end else if (clear) begin
      acc       <= '0;
      mse_valid <= 1'b0;
    end else begin
      mse_valid <= vld_q[3] & ctrl_q[3].last;
      if (vld_q[3]) acc <= acc_next;
      if (vld_q[3] && ctrl_q[3].last) begin
        mse_value <= acc_next;
        mse_ref   <= ctrl_q[3].tag;
      end
    end
  end

`ifdef HSID_MSE_STATS_EN
  logic [HSP_BANDS_WIDTH-1:0] pack_cnt;
  logic [HSP_BANDS_WIDTH-1:0] pack_cnt_next;
  logic [HSP_BANDS_WIDTH-1:0] packs_expected;

  always_comb begin
    pack_cnt_next  = ctrl_q[3].start ? HSP_BANDS_WIDTH'(1) : pack_cnt + 1'b1;
    packs_expected = HSP_BANDS_WIDTH'(hsid_expected_packs(32'(cfg_hsp_bands)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_cnt       <= '0;
      mse_pack_count <= '0;
      mse_pack_error <= 1'b0;
    end else if (clear) begin
      pack_cnt       <= '0;
      mse_pack_error <= 1'b0;
    end else begin
      if (vld_q[3]) pack_cnt <= pack_cnt_next;
      if (vld_q[3] && ctrl_q[3].last) begin
        mse_pack_count <= pack_cnt_next;
        mse_pack_error <= (pack_cnt_next != packs_expected);
      end else begin
        mse_pack_error <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg_bands;
  assign unused_cfg_bands = ^cfg_hsp_bands[HSP_BANDS_WIDTH-1:1];
`endif

endmodule

// File: tb/tb_hsid_mse.sv
// Scoreboard bench for hsid_mse: expected results queued when a last pack is driven, popped on mse_valid.
// Build with HSID_MSE_STATS_EN defined to also check the pack counter outputs.
module tb_hsid_mse;
  import hsid_pkg::*;

  localparam int W  = HSID_WORD_WIDTH;
  localparam int DW = HSID_DATA_WIDTH;
  localparam int BW = HSID_HSP_BANDS_WIDTH;
  localparam int LW = HSID_HSP_LIBRARY_WIDTH;
  localparam int MW = HSID_MSE_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [BW-1:0] cfg_hsp_bands;
  logic          band_pack_valid;
  logic          band_pack_start;
  logic          band_pack_last;
  logic [W-1:0]  band_pack_a;
  logic [W-1:0]  band_pack_b;
  logic [LW-1:0] hsp_ref_count;
  logic          mse_valid;
  logic [MW-1:0] mse_value;
  logic [LW-1:0] mse_ref;
`ifdef HSID_MSE_STATS_EN
  logic [BW-1:0] mse_pack_count;
  logic          mse_pack_error;
`endif

  hsid_mse dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .cfg_hsp_bands   (cfg_hsp_bands),
    .band_pack_valid (band_pack_valid),
    .band_pack_start (band_pack_start),
    .band_pack_last  (band_pack_last),
    .band_pack_a     (band_pack_a),
    .band_pack_b     (band_pack_b),
    .hsp_ref_count   (hsp_ref_count),
    .mse_valid       (mse_valid),
    .mse_value       (mse_value),
    .mse_ref         (mse_ref)
`ifdef HSID_MSE_STATS_EN
    ,
    .mse_pack_count  (mse_pack_count),
    .mse_pack_error  (mse_pack_error)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [MW-1:0] value;
    logic [LW-1:0] tag;
    int            due;
    int            count;
    bit            err;
  } exp_t;

  exp_t          sbq[$];
  exp_t          got_e;
  int            checks = 0;
  int            errors = 0;
  logic [MW-1:0] model_acc = '0;
  int            model_cnt = 0;
  logic [W-1:0]  pa [16];
  logic [W-1:0]  pb [16];
  bit            prev_valid = 0;
  logic [MW-1:0] held_value;
  logic [LW-1:0] held_ref;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [MW-1:0] modelPair(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input bit mask_hi);
    longint alo = a[DW-1:0];
    longint blo = b[DW-1:0];
    longint ahi = a[W-1:DW];
    longint bhi = b[W-1:DW];
    longint s   = (alo - blo) * (alo - blo);
    if (!mask_hi) s += (ahi - bhi) * (ahi - bhi);
    return MW'(s);
  endfunction

  task automatic driveIdle();
    band_pack_valid = 0;
    band_pack_start = 0;
    band_pack_last  = 0;
    clear           = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      driveIdle();
    end
  endtask

  task automatic clearCycle();
    @(posedge clk); #1;
    driveIdle();
    clear     = 1;
    model_acc = '0;
    model_cnt = 0;
  endtask

  task automatic drivePack(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit l,
                           input logic [LW-1:0] tag, input bit with_clear, input bit push);
    exp_t e;
    @(posedge clk); #1;
    band_pack_valid = 1;
    band_pack_start = s;
    band_pack_last  = l;
    band_pack_a     = a;
    band_pack_b     = b;
    hsp_ref_count   = tag;
    clear           = with_clear;
    if (with_clear) begin
      model_acc = '0;
      model_cnt = 0;
    end else begin
      if (s) begin
        model_acc = modelPair(a, b, l && cfg_hsp_bands[0]);
        model_cnt = 1;
      end else begin
        model_acc = model_acc + modelPair(a, b, l && cfg_hsp_bands[0]);
        model_cnt++;
      end
      if (l && push) begin
        e.value = model_acc;
        e.tag   = tag;
        e.due   = cyc + HSID_MSE_LATENCY;
        e.count = model_cnt;
        e.err   = (model_cnt != int'((cfg_hsp_bands + 1) / 2));
        sbq.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input int n, input logic [LW-1:0] tag, input bit with_start,
                               input bit push);
    for (int p = 0; p < n; p++)
      drivePack(pa[p], pb[p], with_start && (p == 0), p == n - 1, tag, 1'b0, push);
  endtask

  // Output monitor: pops the scoreboard on every strobe, checks hold in the cycle after.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
    end else begin
      if (mse_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_valid", 64'(mse_valid), 64'd0);
        end else begin
          got_e = sbq.pop_front();
          checkOutput("mse_value", 64'(mse_value), 64'(got_e.value));
          checkOutput("mse_ref", 64'(mse_ref), 64'(got_e.tag));
          checkOutput("latency", 64'(cyc), 64'(got_e.due));
`ifdef HSID_MSE_STATS_EN
          checkOutput("pack_count", 64'(mse_pack_count), 64'(got_e.count));
          checkOutput("pack_error", 64'(mse_pack_error), 64'(got_e.err));
`endif
        end
      end else if (prev_valid) begin
        checkOutput("hold_value", 64'(mse_value), 64'(held_value));
        checkOutput("hold_ref", 64'(mse_ref), 64'(held_ref));
      end
      prev_valid = mse_valid;
      held_value = mse_value;
      held_ref   = mse_ref;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout, pending=%0d", sbq.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1;
    cfg_hsp_bands = BW'(3);
    hsp_ref_count = '0;
    band_pack_a   = '0;
    band_pack_b   = '0;
    driveIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(mse_valid), 64'd0);
    checkOutput("reset_value", 64'(mse_value), 64'd0);
    checkOutput("reset_ref", 64'(mse_ref), 64'd0);
    rst = 0;
    idleCycles(2);

    $display("[TB] two-pack vector, odd band count");
    pa[0] = {16'd2, 16'd10};  pb[0] = {16'd5, 16'd7};
    pa[1] = {16'd100, 16'd1}; pb[1] = {16'd0, 16'd4};
    applyStimulus(2, LW'(7), 1, 1);
    idleCycles(8);

    $display("[TB] single start+last pack at full scale");
    cfg_hsp_bands = BW'(2);
    pa[0] = {16'hFFFF, 16'h0000}; pb[0] = {16'h0000, 16'hFFFF};
    applyStimulus(1, LW'(3), 1, 1);
    idleCycles(8);

    $display("[TB] back-to-back vectors");
    cfg_hsp_bands = BW'(4);
    pa[0] = {16'd4, 16'd2}; pb[0] = '0;
    pa[1] = {16'd4, 16'd2}; pb[1] = '0;
    applyStimulus(2, LW'(0), 1, 1);
    pa[0] = {16'd0, 16'd3}; pb[0] = '0;
    pa[1] = {16'd0, 16'd0}; pb[1] = {16'd0, 16'd3};
    applyStimulus(2, LW'(1), 1, 1);
    idleCycles(8);

    $display("[TB] clear with a vector in flight");
    cfg_hsp_bands = BW'(2);
    drivePack({16'd3, 16'd3}, '0, 1, 1, LW'(9), 1'b0, 1'b0);
    idleCycles(1);
    clearCycle();
    drivePack({16'd50, 16'd50}, '0, 1, 0, LW'(9), 1'b1, 1'b0);
    drivePack({16'd6, 16'd1}, {16'd1, 16'd6}, 0, 1, LW'(5), 1'b0, 1'b1);
    pa[0] = {16'd9, 16'd8}; pb[0] = {16'd1, 16'd2};
    applyStimulus(1, LW'(6), 1, 1);
    idleCycles(8);

    $display("[TB] async reset mid-vector");
    cfg_hsp_bands = BW'(3);
    drivePack({16'd2, 16'd10}, {16'd5, 16'd7}, 1, 0, LW'(7), 1'b0, 1'b0);
    @(posedge clk); #1;
    driveIdle();
    rst = 1;
    #1;
    checkOutput("rst_valid", 64'(mse_valid), 64'd0);
    checkOutput("rst_value", 64'(mse_value), 64'd0);
    checkOutput("rst_ref", 64'(mse_ref), 64'd0);
    model_acc = '0;
    model_cnt = 0;
    @(posedge clk); #1;
    rst = 0;
    pa[0] = {16'd2, 16'd10};  pb[0] = {16'd5, 16'd7};
    pa[1] = {16'd100, 16'd1}; pb[1] = {16'd0, 16'd4};
    applyStimulus(2, LW'(11), 1, 1);
    idleCycles(8);

    $display("[TB] short and full vectors with five bands");
    cfg_hsp_bands = BW'(5);
    pa[0] = {16'd1, 16'd2}; pb[0] = {16'd4, 16'd0};
    pa[1] = {16'd7, 16'd3}; pb[1] = {16'd0, 16'd5};
    pa[2] = {16'd9, 16'd8}; pb[2] = {16'd2, 16'd1};
    applyStimulus(2, LW'(12), 1, 1);
    applyStimulus(3, LW'(13), 1, 1);
    idleCycles(2);

    $display("[TB] pack without a start accumulates onto the previous sum");
    pa[0] = {16'd10, 16'd20}; pb[0] = {16'd0, 16'd17};
    applyStimulus(1, LW'(14), 0, 1);
    idleCycles(8);

    $display("[TB] random vectors");
    for (int v = 0; v < 8; v++) begin
      cfg_hsp_bands = BW'($urandom_range(1, 24));
      for (int p = 0; p < 16; p++) begin
        pa[p] = W'($urandom);
        pb[p] = W'($urandom);
      end
      applyStimulus(int'((cfg_hsp_bands + 1) / 2), LW'(20 + v), 1, 1);
      applyStimulus(int'((cfg_hsp_bands + 1) / 2), LW'(40 + v), 1, 1);
      idleCycles(7);
    end

    idleCycles(10);
    checkOutput("pending_results", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
